// File: rtl/fsm_mod_counter.sv
// rtl/fsm_mod_counter.sv - modulo-N up/down counter FSM with load, terminal-count pulse,
// saturating wrap counter and optional Gray-coded output.
module fsm_mod_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 8,
  parameter int GRAY_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic [7:0]       wraps
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  // One extra bit so MODULO = 2^WIDTH compares correctly against din.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q, q_next;
  logic             tc_next;
  logic [7:0]       wraps_next;
  logic [7:0]       wraps_inc;
  op_t              op;

  always_comb begin
    op = OP_HOLD;
    if (load)
      op = OP_LOAD;
    else if (w)
      op = dir ? OP_UP : OP_DOWN;
  end

  assign wraps_inc = (wraps == 8'hFF) ? wraps : wraps + 8'd1;

  always_comb begin
    q_next     = q;
    tc_next    = 1'b0;
    wraps_next = wraps;
    case (op)
      OP_LOAD: begin
        q_next = ({1'b0, din} < MOD_EXT) ? din : LAST;
      end
      OP_UP: begin
        if (q == LAST) begin
          q_next     = '0;
          tc_next    = 1'b1;
          wraps_next = wraps_inc;
        end else begin
          q_next = q + 1'b1;
        end
      end
      OP_DOWN: begin
        if (q == '0) begin
          q_next     = LAST;
          tc_next    = 1'b1;
          wraps_next = wraps_inc;
        end else begin
          q_next = q - 1'b1;
        end
      end
      default: begin
        q_next = q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      tc    <= 1'b0;
      wraps <= 8'd0;
    end else begin
      q     <= q_next;
      tc    <= tc_next;
      wraps <= wraps_next;
    end
  end

  generate
    if (GRAY_OUT != 0) begin : g_gray
      assign y = q ^ (q >> 1);
    end else begin : g_bin
      assign y = q;
    end
  endgenerate

endmodule
